// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes and widths shared by the ALU and its arbiter.
package alu_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int SHAMT_W      = 5;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRA  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: the shared execute-stage ALU; unassigned op codes produce zero.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] y_o
);
    logic [SHAMT_W-1:0] sh;
    assign sh = b_i[SHAMT_W-1:0];
    always_comb begin
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << sh;
            ALU_SRA:  y_o = $signed(a_i) >>> sh;
            ALU_SRL:  y_o = a_i >> sh;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SLT:  y_o = XLEN'($signed(a_i) < $signed(b_i));
            ALU_SLTU: y_o = XLEN'(a_i < b_i);
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NREQ requesters,
// returning each result through a registered, back-pressurable slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][XLEN-1:0] req_a,
    input  logic [NREQ-1:0][XLEN-1:0] req_b,
    input  logic [NREQ-1:0][3:0]      req_op,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [XLEN-1:0]           rsp_data
);
    localparam int OW = $clog2(NREQ);

    logic            res_valid_q, res_valid_d;
    logic [OW-1:0]   res_owner_q, res_owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [OW-1:0]   gnt_idx;
    logic            gnt_any, slot_free, hs;
    logic [XLEN-1:0] alu_y;

    // Returns {found, index} of the first valid requester after the last grant.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] v, input logic [OW-1:0] last);
        logic [OW:0]   r;
        logic [OW-1:0] idx;
        r = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(last) + k) % NREQ);
            if (!r[OW] && v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign {gnt_any, gnt_idx} = rr_pick(req_valid, last_q);

    always_comb begin
        slot_free   = !res_valid_q || rsp_ready[res_owner_q];
        hs          = !rst && slot_free && gnt_any;
        req_ready   = hs ? NREQ'(1) << gnt_idx : '0;
        res_valid_d = hs || (res_valid_q && !rsp_ready[res_owner_q]);
        res_owner_d = hs ? gnt_idx : res_owner_q;
        last_d      = hs ? gnt_idx : last_q;
        res_d       = hs ? alu_y : res_q;
    end

    alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
        .a_i  (req_a[gnt_idx]),
        .b_i  (req_b[gnt_idx]),
        .op_i (req_op[gnt_idx]),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_owner_q <= '0;
            res_q       <= '0;
            last_q      <= OW'(NREQ - 1);
        end else begin
            res_valid_q <= res_valid_d;
            res_owner_q <= res_owner_d;
            res_q       <= res_d;
            last_q      <= last_d;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        assign rsp_valid[i] = !rst && res_valid_q && (res_owner_q == OW'(i));
    end

    assign rsp_data = res_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model of the response slot and round-robin pointer.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int OW   = $clog2(NREQ);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NREQ-1:0]           req_valid = '0;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][XLEN-1:0] req_a = '0;
    logic [NREQ-1:0][XLEN-1:0] req_b = '0;
    logic [NREQ-1:0][3:0]      req_op = '0;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready = '0;
    logic [XLEN-1:0]           rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid;
    int          m_owner;
    int          m_last;
    logic [31:0] m_res;

    logic [31:0] ct_a [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
    logic [31:0] ct_b [4] = '{32'd1, 32'd1, 32'd33, 32'd8};
    logic [3:0]  ct_op[4] = '{4'd7, 4'd8, 4'd3, 4'd0};
    logic [31:0] ct_y [4] = '{32'd1, 32'd0, 32'hC000_0000, 32'd15};

    logic [3:0]  bb_op[4] = '{4'd0, 4'd6, 4'd2, 4'd9};
    logic [31:0] bb_a [4] = '{32'd10, 32'h0000_F0F0, 32'd1, 32'h0000_00FF};
    logic [31:0] bb_b [4] = '{32'd20, 32'h0000_FF00, 32'd36, 32'h0000_000F};
    logic [31:0] bb_y [4] = '{32'd30, 32'h0000_0FF0, 32'd16, 32'h0000_000F};

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return a[31] ? ~((~a) >> sh) : a >> sh;
            4'd4: return a >> sh;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return (a < b) ? 32'd1 : 32'd0;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] r;
        r = '0;
        if (i >= 0) r[OW'(i)] = 1'b1;
        return r;
    endfunction

    function automatic int exp_grant();
        int c;
        if (rst) return -1;
        if (m_valid && !rsp_ready[OW'(m_owner)]) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (req_valid[OW'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        int g;
        logic [OW-1:0] gi;
        g = exp_grant();
        gi = OW'(g < 0 ? 0 : g);
        if (rst) begin
            m_valid = 1'b0; m_owner = 0; m_res = '0; m_last = NREQ - 1;
        end else if (g >= 0) begin
            m_res = ref_alu(req_op[gi], req_a[gi], req_b[gi]);
            m_owner = g; m_valid = 1'b1; m_last = g;
        end else if (m_valid && rsp_ready[OW'(m_owner)]) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[OW'(i)] = v;
        req_op[OW'(i)] = op;
        req_a[OW'(i)] = a;
        req_b[OW'(i)] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = '1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== '0 || rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: req_ready=%b rsp_valid=%b, want 00/00", req_ready, rsp_valid);
        end
        tick();
        n_tests++;
        if (rsp_valid !== '0 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rsp_valid=%b rsp_data=%h, want 00/0", rsp_valid, rsp_data);
        end
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: req_ready=%b, want 00", req_ready);
        end
        tick();
    endtask

    task automatic test_single();
        rsp_ready = '1;
        set_req(0, 1'b1, 4'd1, 32'd5, 32'd3);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b, want 01", req_ready);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin
            n_fail++;
            $display("FAIL single_rsp: rsp_valid=%b rsp_data=%0d, want 01/2", rsp_valid, rsp_data);
        end
        req_valid = '0;
        tick();
        n_tests++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL single_drain: rsp_valid=%b, want 00", rsp_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        rsp_ready = '1;
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, ct_op[c], ct_a[c], ct_b[c]);
            set_req(1, 1'b1, ct_op[c], ct_a[c], ct_b[c]);
            @(negedge clk);
            n_tests++;
            if (req_ready !== onehot(c % 2)) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: req_ready=%b, want %b", c, req_ready, onehot(c % 2));
            end
            tick();
            n_tests++;
            if (rsp_valid !== onehot(c % 2) || rsp_data !== ct_y[c]) begin
                n_fail++;
                $display("FAIL contention_rsp[%0d]: rsp_valid=%b rsp_data=%h, want %b/%h",
                         c, rsp_valid, rsp_data, onehot(c % 2), ct_y[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        req_valid = '0;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        rsp_ready = 2'b10;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_grant0: req_ready=%b, want 01", req_ready);
        end
        tick();
        req_valid = '0;
        set_req(1, 1'b1, 4'd0, 32'd3, 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== '0 || rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: req_ready=%b rsp_valid=%b rsp_data=%0d, want 00/01/2",
                         c, req_ready, rsp_valid, rsp_data);
            end
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: req_ready=%b, want 10", req_ready);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd7) begin
            n_fail++;
            $display("FAIL bp_rsp1: rsp_valid=%b rsp_data=%0d, want 10/7", rsp_valid, rsp_data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_illegal();
        rsp_ready = '1;
        set_req(0, 1'b1, 4'd12, 32'h0000_FFFF, 32'd1);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL illegal_grant: req_ready=%b, want 01", req_ready);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL illegal_rsp: rsp_valid=%b rsp_data=%h, want 01/0", rsp_valid, rsp_data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = '0;
        set_req(0, 1'b1, 4'd0, 32'd9, 32'd1);
        tick();
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd10) begin
            n_fail++;
            $display("FAIL rmid_pending: rsp_valid=%b rsp_data=%0d, want 01/10", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        set_req(0, 1'b1, 4'd0, 32'd100, 32'd1);
        set_req(1, 1'b1, 4'd0, 32'd200, 32'd1);
        tick();
        rst = 1'b0;
        n_tests++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL rmid_discard: rsp_valid=%b, want 00", rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_first_grant: req_ready=%b, want 01", req_ready);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd101) begin
            n_fail++;
            $display("FAIL rmid_rsp: rsp_valid=%b rsp_data=%0d, want 01/101", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = '1;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            set_req(1, 1'b1, bb_op[c], bb_a[c], bb_b[c]);
            @(negedge clk);
            n_tests++;
            if (req_ready !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: req_ready=%b, want 10", c, req_ready);
            end
            tick();
            n_tests++;
            if (rsp_valid !== 2'b10 || rsp_data !== bb_y[c]) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d]: rsp_valid=%b rsp_data=%h, want 10/%h", c, rsp_valid, rsp_data, bb_y[c]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] special [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom,
                        ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom);
                rsp_ready[OW'(i)] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            n_tests++;
            if (req_ready !== onehot(exp_grant())) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: req_ready=%b, want %b", c, req_ready, onehot(exp_grant()));
            end
            tick();
            n_tests++;
            if (rsp_valid !== (m_valid ? onehot(m_owner) : '0) || rsp_data !== m_res) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: rsp_valid=%b rsp_data=%h, want %b/%h",
                         c, rsp_valid, rsp_data, m_valid ? onehot(m_owner) : '0, m_res);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0; m_owner = 0; m_last = NREQ - 1; m_res = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
